pwm_ramp_ctrl: RTL and testbench

Controller that sequences the `pwm` datapath for the gate driver. It drives `pwm.ena` and `pwm.duty`, and walks the duty cycle toward a requested target in bounded steps, one step per PWM period (soft start, soft stop, retarget). A fault input forces the PWM off immediately and latches the fault until software clears it.

---
 rtl/pwm_ramp_ctrl_if.sv | 26 ++
 rtl/pwm_ramp_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_ctrl_if.sv
// rtl/pwm_ramp_ctrl_if.sv - duty-target handshake bundle for pwm_ramp_ctrl
//
// Signals:
//   tgt_duty   requested duty target (N bits), master -> slave
//   tgt_valid  target valid, master -> slave
//   tgt_ready  target ready, slave -> master
// The controller is the slave; software or the testbench is the master.
interface pwm_ramp_ctrl_if #(
    parameter int N = 8
);
    logic [N-1:0] tgt_duty;
    logic         tgt_valid;
    logic         tgt_ready;

    modport master (
        output tgt_duty,
        output tgt_valid,
        input  tgt_ready
    );

    modport slave (
        input  tgt_duty,
        input  tgt_valid,
        output tgt_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - soft-start/soft-stop duty sequencer for the gate-driver pwm
//
// Walks pwm_duty toward a requested target in bounded steps, one step per
// PWM period (2^N clocks), and forces the PWM off on an external fault
// until software clears it.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset, shared with the pwm instance
//   enable         1 = run / ramp to target, 0 = soft stop
//   tgt            target handshake (slave side): tgt_duty, tgt_valid, tgt_ready
//   step           duty change per period; 0 behaves as 1
//   fault          external fault, level-sensitive
//   fault_clr      clears the latched fault once fault has dropped
//   pwm_ena        enable to the pwm instance
//   pwm_duty       registered duty to the pwm instance
//   at_target      state is HOLD
//   busy           state is RAMP or STOP
//   fault_latched  state is FAULT
module pwm_ramp_ctrl #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    pwm_ramp_ctrl_if.slave   tgt,
    input  logic [N-1:0]     step,
    input  logic             fault,
    input  logic             fault_clr,
    output logic             pwm_ena,
    output logic [N-1:0]     pwm_duty,
    output logic             at_target,
    output logic             busy,
    output logic             fault_latched
);

    localparam logic [N-1:0] ONE  = N'(1);
    localparam logic [N-1:0] ZERO = '0;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_RAMP  = 3'd1,
        S_HOLD  = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t       state;
    logic [N-1:0] cnt;
    logic [N-1:0] duty_r;
    logic [N-1:0] target_r;
    logic         ena_r;

    logic         boundary;
    logic         accept;
    logic [N-1:0] step_eff;
    logic [N-1:0] ramp_next;
    logic [N-1:0] stop_next;

    // One step from cur toward dest, clamped at dest. The sum/difference is
    // formed one bit wider so that neither direction can wrap.
    function automatic logic [N-1:0] step_toward(
        input logic [N-1:0] cur,
        input logic [N-1:0] dest,
        input logic [N-1:0] s
    );
        logic [N:0]   wide;
        logic [N-1:0] res;
        res  = cur;
        wide = '0;
        if (dest > cur) begin
            wide = {1'b0, cur} + {1'b0, s};
            res  = (wide > {1'b0, dest}) ? dest : wide[N-1:0];
        end else if (dest < cur) begin
            wide = {1'b0, dest} + {1'b0, s};
            res  = ({1'b0, cur} < wide) ? dest : (cur - s);
        end
        return res;
    endfunction

    // The counter wraps together with the pwm instance's counter because
    // both are cleared by the same rst; the last count of each period is
    // where the next period's duty gets registered.
    assign boundary  = (cnt == '1);
    assign step_eff  = (step == ZERO) ? ONE : step;
    assign ramp_next = step_toward(duty_r, target_r, step_eff);
    assign stop_next = step_toward(duty_r, ZERO, step_eff);

    assign tgt.tgt_ready = (state != S_FAULT);
    assign accept        = tgt.tgt_valid && (state != S_FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_OFF;
            cnt      <= '0;
            duty_r   <= '0;
            target_r <= '0;
            ena_r    <= 1'b0;
        end else begin
            cnt <= cnt + ONE;

            // Target preload/retarget is independent of the state walk; the
            // step below still sees the old target_r on the same edge.
            if (accept) begin
                target_r <= tgt.tgt_duty;
            end

            if (fault) begin
                // Fault wins over any step, stop or handshake in this cycle.
                state    <= S_FAULT;
                ena_r    <= 1'b0;
                duty_r   <= '0;
                target_r <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        ena_r  <= 1'b0;
                        duty_r <= '0;
                        if (enable) begin
                            state <= S_RAMP;
                            ena_r <= 1'b1;
                        end
                    end

                    S_RAMP: begin
                        if (!enable) begin
                            state <= S_STOP;
                        end else if (duty_r == target_r) begin
                            state <= S_HOLD;
                        end else if (boundary) begin
                            duty_r <= ramp_next;
                            if (ramp_next == target_r) begin
                                state <= S_HOLD;
                            end
                        end
                    end

                    S_HOLD: begin
                        if (!enable) begin
                            state <= S_STOP;
                        end else if (target_r != duty_r) begin
                            state <= S_RAMP;
                        end
                    end

                    S_STOP: begin
                        if (enable) begin
                            state <= S_RAMP;
                        end else if (duty_r == ZERO) begin
                            // Zero duty has already been registered for a
                            // cycle, so the enable can drop now.
                            state <= S_OFF;
                            ena_r <= 1'b0;
                        end else if (boundary) begin
                            duty_r <= stop_next;
                        end
                    end

                    S_FAULT: begin
                        ena_r    <= 1'b0;
                        duty_r   <= '0;
                        target_r <= '0;
                        if (fault_clr) begin
                            state <= S_OFF;
                        end
                    end

                    default: begin
                        state  <= S_OFF;
                        ena_r  <= 1'b0;
                        duty_r <= '0;
                    end
                endcase
            end
        end
    end

    assign pwm_ena       = ena_r;
    assign pwm_duty      = duty_r;
    assign at_target     = (state == S_HOLD);
    assign busy          = (state == S_RAMP) || (state == S_STOP);
    assign fault_latched = (state == S_FAULT);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] step;
    logic       fault;
    logic       fault_clr;
    logic       pwm_ena;
    logic [7:0] pwm_duty;
    logic       at_target;
    logic       busy;
    logic       fault_latched;

    logic [7:0] phase;
    int         checks;
    int         errors;

    pwm_ramp_ctrl_if #(.N(8)) tgt_if ();

    pwm_ramp_ctrl #(.N(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .tgt           (tgt_if),
        .step          (step),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .pwm_ena       (pwm_ena),
        .pwm_duty      (pwm_duty),
        .at_target     (at_target),
        .busy          (busy),
        .fault_latched (fault_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side period position: 0 right after the edge that wraps the
    // period, i.e. the first cycle in which a boundary update is visible.
    always @(posedge clk) begin
        if (rst) phase <= 8'd0;
        else     phase <= phase + 8'd1;
    end

    // Reference step rule: move by s (0 counts as 1) toward dest, no overshoot.
    function automatic int model_step(input int d, input int dest, input int st);
        int s;
        s = (st == 0) ? 1 : st;
        if (dest > d) return (d + s > dest) ? dest : d + s;
        if (dest < d) return (d - s < dest) ? dest : d - s;
        return d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        fault = 1'b0;
        fault_clr = 1'b0;
        step = 8'd0;
        tgt_if.tgt_valid = 1'b0;
        tgt_if.tgt_duty = 8'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_target(input int t);
        tgt_if.tgt_duty = 8'(t);
        tgt_if.tgt_valid = 1'b1;
        @(negedge clk);
        tgt_if.tgt_valid = 1'b0;
    endtask

    task automatic wait_boundary();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (phase != 8'd0 && n < 300);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (pwm_ena !== 1'b0) begin errors++; $display("FAIL reset_ena: got %b expected 0", pwm_ena); end
        if (pwm_duty !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", pwm_duty); end
        if (at_target !== 1'b0) begin errors++; $display("FAIL reset_at_target: got %b expected 0", at_target); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (fault_latched !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault_latched); end
        if (tgt_if.tgt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tgt_if.tgt_ready); end
    endtask

    task automatic test_ramp_up();
        int exp_d [4] = '{32, 64, 96, 128};
        step = 8'd32;
        send_target(128);
        enable = 1'b1;
        @(negedge clk);
        checks += 3;
        if (pwm_ena !== 1'b1) begin errors++; $display("FAIL rampup_ena: got %b expected 1", pwm_ena); end
        if (busy !== 1'b1) begin errors++; $display("FAIL rampup_busy: got %b expected 1", busy); end
        if (pwm_duty !== 8'd0) begin errors++; $display("FAIL rampup_duty0: got %0d expected 0", pwm_duty); end
        for (int i = 0; i < 4; i++) begin
            wait_boundary();
            checks += 2;
            if (pwm_duty !== 8'(exp_d[i])) begin errors++; $display("FAIL rampup_duty[%0d]: got %0d expected %0d", i, pwm_duty, exp_d[i]); end
            if (at_target !== (i == 3)) begin errors++; $display("FAIL rampup_at_target[%0d]: got %b expected %b", i, at_target, (i == 3)); end
        end
        checks += 1;
        if (busy !== 1'b0) begin errors++; $display("FAIL rampup_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_retarget();
        int exp_d [2] = '{96, 64};
        send_target(64);
        @(negedge clk);
        checks += 2;
        if (at_target !== 1'b0) begin errors++; $display("FAIL retarget_leave_hold: got %b expected 0", at_target); end
        if (pwm_duty !== 8'd128) begin errors++; $display("FAIL retarget_no_early_step: got %0d expected 128", pwm_duty); end
        for (int i = 0; i < 2; i++) begin
            wait_boundary();
            checks += 2;
            if (pwm_duty !== 8'(exp_d[i])) begin errors++; $display("FAIL retarget_duty[%0d]: got %0d expected %0d", i, pwm_duty, exp_d[i]); end
            if (at_target !== (i == 1)) begin errors++; $display("FAIL retarget_at_target[%0d]: got %b expected %b", i, at_target, (i == 1)); end
        end
    endtask

    task automatic test_soft_stop();
        step = 8'd64;
        send_target(128);
        wait_boundary();
        checks += 2;
        if (pwm_duty !== 8'd128) begin errors++; $display("FAIL stop_pre_duty: got %0d expected 128", pwm_duty); end
        if (at_target !== 1'b1) begin errors++; $display("FAIL stop_pre_hold: got %b expected 1", at_target); end
        enable = 1'b0;
        @(negedge clk);
        checks += 1;
        if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy: got %b expected 1", busy); end
        wait_boundary();
        checks += 1;
        if (pwm_duty !== 8'd64) begin errors++; $display("FAIL stop_duty64: got %0d expected 64", pwm_duty); end
        wait_boundary();
        checks += 2;
        if (pwm_duty !== 8'd0) begin errors++; $display("FAIL stop_duty0: got %0d expected 0", pwm_duty); end
        if (pwm_ena !== 1'b1) begin errors++; $display("FAIL stop_ena_hold: got %b expected 1", pwm_ena); end
        @(negedge clk);
        checks += 2;
        if (pwm_ena !== 1'b0) begin errors++; $display("FAIL stop_ena_drop: got %b expected 0", pwm_ena); end
        if (busy !== 1'b0) begin errors++; $display("FAIL stop_off: got %b expected 0", busy); end
        // Restart, then re-enable in the middle of a soft stop.
        enable = 1'b1;
        wait_boundary();
        wait_boundary();
        checks += 1;
        if (pwm_duty !== 8'd128) begin errors++; $display("FAIL restart_duty: got %0d expected 128", pwm_duty); end
        enable = 1'b0;
        wait_boundary();
        checks += 1;
        if (pwm_duty !== 8'd64) begin errors++; $display("FAIL midstop_duty: got %0d expected 64", pwm_duty); end
        enable = 1'b1;
        wait_boundary();
        checks += 2;
        if (pwm_duty !== 8'd128) begin errors++; $display("FAIL resume_duty: got %0d expected 128", pwm_duty); end
        if (at_target !== 1'b1) begin errors++; $display("FAIL resume_hold: got %b expected 1", at_target); end
    endtask

    task automatic test_saturate();
        int exp_d [3] = '{50, 100, 128};
        do_reset();
        step = 8'd50;
        send_target(128);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_boundary();
            checks += 2;
            if (pwm_duty !== 8'(exp_d[i])) begin errors++; $display("FAIL sat_duty[%0d]: got %0d expected %0d", i, pwm_duty, exp_d[i]); end
            if (at_target !== (i == 2)) begin errors++; $display("FAIL sat_at_target[%0d]: got %b expected %b", i, at_target, (i == 2)); end
        end
        wait_boundary();
        checks += 1;
        if (pwm_duty !== 8'd128) begin errors++; $display("FAIL sat_hold_duty: got %0d expected 128", pwm_duty); end
    endtask

    task automatic test_fault();
        int n;
        do_reset();
        step = 8'd32;
        send_target(128);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_boundary();
        checks += 1;
        if (pwm_duty !== 8'd96) begin errors++; $display("FAIL fault_pre_duty: got %0d expected 96", pwm_duty); end
        n = 0;
        while (phase != 8'd255 && n < 300) begin @(negedge clk); n++; end
        fault = 1'b1;
        @(negedge clk);
        checks += 5;
        if (pwm_duty !== 8'd0) begin errors++; $display("FAIL fault_duty: got %0d expected 0", pwm_duty); end
        if (pwm_ena !== 1'b0) begin errors++; $display("FAIL fault_ena: got %b expected 0", pwm_ena); end
        if (fault_latched !== 1'b1) begin errors++; $display("FAIL fault_latched: got %b expected 1", fault_latched); end
        if (tgt_if.tgt_ready !== 1'b0) begin errors++; $display("FAIL fault_ready: got %b expected 0", tgt_if.tgt_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL fault_busy: got %b expected 0", busy); end
        // Clear while fault is still present, with a target offered: both ignored.
        fault_clr = 1'b1;
        tgt_if.tgt_duty = 8'd200;
        tgt_if.tgt_valid = 1'b1;
        repeat (3) @(negedge clk);
        tgt_if.tgt_valid = 1'b0;
        checks += 1;
        if (fault_latched !== 1'b1) begin errors++; $display("FAIL fault_clr_ignored: got %b expected 1", fault_latched); end
        fault = 1'b0;
        @(negedge clk);
        fault_clr = 1'b0;
        checks += 3;
        if (fault_latched !== 1'b0) begin errors++; $display("FAIL fault_cleared: got %b expected 0", fault_latched); end
        if (tgt_if.tgt_ready !== 1'b1) begin errors++; $display("FAIL fault_ready_back: got %b expected 1", tgt_if.tgt_ready); end
        if (pwm_ena !== 1'b0) begin errors++; $display("FAIL fault_off_ena: got %b expected 0", pwm_ena); end
        wait_boundary();
        wait_boundary();
        checks += 1;
        if (pwm_duty !== 8'd0) begin errors++; $display("FAIL fault_target_zero: got %0d expected 0", pwm_duty); end
    endtask

    task automatic test_step_zero();
        int exp_d [3] = '{1, 2, 3};
        do_reset();
        step = 8'd0;
        send_target(3);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_boundary();
            checks += 1;
            if (pwm_duty !== 8'(exp_d[i])) begin errors++; $display("FAIL step0_duty[%0d]: got %0d expected %0d", i, pwm_duty, exp_d[i]); end
        end
        checks += 1;
        if (at_target !== 1'b1) begin errors++; $display("FAIL step0_hold: got %b expected 1", at_target); end
        send_target(10);
        wait_boundary();
        repeat (20) @(negedge clk);
        checks += 1;
        if (busy !== 1'b1) begin errors++; $display("FAIL step0_midramp: got %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks += 6;
        if (pwm_ena !== 1'b0) begin errors++; $display("FAIL midrst_ena: got %b expected 0", pwm_ena); end
        if (pwm_duty !== 8'd0) begin errors++; $display("FAIL midrst_duty: got %0d expected 0", pwm_duty); end
        if (at_target !== 1'b0) begin errors++; $display("FAIL midrst_at_target: got %b expected 0", at_target); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (fault_latched !== 1'b0) begin errors++; $display("FAIL midrst_fault: got %b expected 0", fault_latched); end
        if (tgt_if.tgt_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", tgt_if.tgt_ready); end
        rst = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_random();
        int cur;
        int t;
        int s;
        int d;
        int q[$];
        do_reset();
        cur = 0;
        for (int trial = 0; trial < 6; trial++) begin
            t = int'($urandom_range(255, 0));
            if (t == cur) t = (cur + 128) % 256;
            s = int'($urandom_range(80, 16));
            q.delete();
            d = cur;
            while (d != t) begin
                d = model_step(d, t, s);
                q.push_back(d);
            end
            step = 8'(s);
            send_target(t);
            enable = 1'b1;
            for (int i = 0; i < q.size(); i++) begin
                wait_boundary();
                checks += 2;
                if (pwm_duty !== 8'(q[i])) begin errors++; $display("FAIL rand%0d_duty[%0d]: got %0d expected %0d (tgt %0d step %0d)", trial, i, pwm_duty, q[i], t, s); end
                if (at_target !== (i == q.size() - 1)) begin errors++; $display("FAIL rand%0d_at_target[%0d]: got %b expected %b", trial, i, at_target, (i == q.size() - 1)); end
            end
            cur = t;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        enable = 1'b0;
        fault = 1'b0;
        fault_clr = 1'b0;
        step = 8'd0;
        tgt_if.tgt_valid = 1'b0;
        tgt_if.tgt_duty = 8'd0;
        test_reset();
        test_ramp_up();
        test_retarget();
        test_soft_stop();
        test_saturate();
        test_fault();
        test_step_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
